// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: NOP encoding, reset
// address default and FSM state encoding.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INSN           = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StKill = 2'd2,
    StHalt = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// One-entry holding buffer for a fetched word that the decoder could not take.
// Priority is clear > load > drain.
module fetch_buffer
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_load,
  input  logic        i_drain,
  input  logic [31:0] i_word,
  input  logic [31:0] i_pc,
  input  logic        i_err,
  output logic        o_full,
  output logic [31:0] o_word,
  output logic [31:0] o_pc,
  output logic        o_err
);

  logic        r_full;
  logic [31:0] r_word;
  logic [31:0] r_pc;
  logic        r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_word <= NOP_INSN;
      r_pc   <= 32'h0;
      r_err  <= 1'b0;
    end else if (i_clear) begin
      r_full <= 1'b0;
      r_err  <= 1'b0;
    end else if (i_load) begin
      r_full <= 1'b1;
      r_word <= i_word;
      r_pc   <= i_pc;
      r_err  <= i_err;
    end else if (i_drain) begin
      r_full <= 1'b0;
      r_err  <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_word = r_word;
  assign o_pc   = r_pc;
  assign o_err  = r_err;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: Wishbone-style single-outstanding fetch with a
// one-entry stall buffer, redirect/kill handling and fault reporting.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] ibus_addr,
  output logic        ibus_cyc,
  output logic        ibus_stb,
  input  logic [31:0] ibus_dat_i,
  input  logic        ibus_ack,
  input  logic        ibus_err,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        fetch_err,
  output logic        misaligned
);

  fetch_state_e r_state, w_state_d;
  logic [31:0]  r_pc, w_pc_d;
  logic [31:0]  r_kill_addr, w_kill_addr_d;
  logic [31:0]  r_instruction, w_instruction_d;
  logic [31:0]  r_inst_pc, w_inst_pc_d;
  logic         r_inst_valid, w_inst_valid_d;
  logic         r_fetch_err, w_fetch_err_d;
  logic         r_misaligned, w_misaligned_d;

  logic         w_busy, w_done;
  logic         w_buf_clear, w_buf_load, w_buf_drain, w_buf_err_in;
  logic [31:0]  w_buf_word_in;
  logic         w_buf_full, w_buf_err;
  logic [31:0]  w_buf_word, w_buf_pc;

  fetch_buffer u_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_buf_clear),
    .i_load  (w_buf_load),
    .i_drain (w_buf_drain),
    .i_word  (w_buf_word_in),
    .i_pc    (r_pc),
    .i_err   (w_buf_err_in),
    .o_full  (w_buf_full),
    .o_word  (w_buf_word),
    .o_pc    (w_buf_pc),
    .o_err   (w_buf_err)
  );

  assign w_busy = (r_state == StReq) || (r_state == StKill);
  assign w_done = ibus_ack || ibus_err;

  always_comb begin
    w_state_d       = r_state;
    w_pc_d          = r_pc;
    w_kill_addr_d   = r_kill_addr;
    w_instruction_d = r_instruction;
    w_inst_pc_d     = r_inst_pc;
    w_inst_valid_d  = r_inst_valid;
    w_fetch_err_d   = r_fetch_err;
    w_misaligned_d  = r_misaligned;
    w_buf_clear     = 1'b0;
    w_buf_load      = 1'b0;
    w_buf_drain     = 1'b0;
    w_buf_word_in   = ibus_dat_i;
    w_buf_err_in    = 1'b0;

    if (redirect) begin
      w_buf_clear     = 1'b1;
      w_instruction_d = NOP_INSN;
      w_inst_valid_d  = 1'b0;
      w_fetch_err_d   = 1'b0;
      w_misaligned_d  = 1'b0;
      if (redirect_pc[1:0] != 2'b00) begin
        w_inst_valid_d = 1'b1;
        w_misaligned_d = 1'b1;
        w_inst_pc_d    = redirect_pc;
        w_state_d      = StHalt;
      end else begin
        w_pc_d = redirect_pc;
        if (w_busy && !w_done) begin
          // Outstanding cycle must complete on its original address first.
          w_state_d = StKill;
          if (r_state == StReq) w_kill_addr_d = r_pc;
        end else begin
          w_state_d = StReq;
        end
      end
    end else begin
      // Decoder consumes the current word when not stalled; a fault stays visible in HALT.
      if (!stall && (r_state != StHalt)) begin
        w_inst_valid_d = 1'b0;
        w_fetch_err_d  = 1'b0;
        w_misaligned_d = 1'b0;
      end
      if (!stall && w_buf_full) begin
        w_buf_drain     = 1'b1;
        w_instruction_d = w_buf_word;
        w_inst_pc_d     = w_buf_pc;
        w_inst_valid_d  = 1'b1;
        w_fetch_err_d   = w_buf_err;
        w_misaligned_d  = 1'b0;
      end

      unique case (r_state)
        StIdle: begin
          if (!stall || !w_buf_full) w_state_d = StReq;
        end
        StReq: begin
          if (ibus_err) begin
            if (stall) begin
              w_buf_load    = 1'b1;
              w_buf_word_in = NOP_INSN;
              w_buf_err_in  = 1'b1;
            end else begin
              w_instruction_d = NOP_INSN;
              w_inst_pc_d     = r_pc;
              w_inst_valid_d  = 1'b1;
              w_fetch_err_d   = 1'b1;
              w_misaligned_d  = 1'b0;
            end
            w_state_d = StHalt;
          end else if (ibus_ack) begin
            w_pc_d = r_pc + 32'd4;
            if (stall) begin
              w_buf_load = 1'b1;
              w_state_d  = StIdle;
            end else begin
              w_instruction_d = ibus_dat_i;
              w_inst_pc_d     = r_pc;
              w_inst_valid_d  = 1'b1;
              w_fetch_err_d   = 1'b0;
              w_misaligned_d  = 1'b0;
            end
          end
        end
        StKill: begin
          if (w_done) w_state_d = StReq;
        end
        StHalt: begin
          w_state_d = StHalt;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_pc          <= RESET_ADDR;
      r_kill_addr   <= RESET_ADDR;
      r_instruction <= NOP_INSN;
      r_inst_pc     <= RESET_ADDR;
      r_inst_valid  <= 1'b0;
      r_fetch_err   <= 1'b0;
      r_misaligned  <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_pc          <= w_pc_d;
      r_kill_addr   <= w_kill_addr_d;
      r_instruction <= w_instruction_d;
      r_inst_pc     <= w_inst_pc_d;
      r_inst_valid  <= w_inst_valid_d;
      r_fetch_err   <= w_fetch_err_d;
      r_misaligned  <= w_misaligned_d;
    end
  end

  assign ibus_cyc    = w_busy;
  assign ibus_stb    = w_busy;
  assign ibus_addr   = (r_state == StKill) ? r_kill_addr : r_pc;
  assign instruction = r_instruction;
  assign inst_pc     = r_inst_pc;
  assign inst_valid  = r_inst_valid;
  assign fetch_err   = r_fetch_err;
  assign misaligned  = r_misaligned;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed sequences, a redirect table and
// a randomized run checked against a program-order stream model.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ibus_addr;
  logic        ibus_cyc, ibus_stb;
  logic [31:0] ibus_dat_i;
  logic        ibus_ack, ibus_err;
  logic        stall, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instruction, inst_pc;
  logic        inst_valid, fetch_err, misaligned;

  int n_vec = 0;
  int n_err = 0;

  fetch_unit #(.RESET_ADDR(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ibus_addr   (ibus_addr),
    .ibus_cyc    (ibus_cyc),
    .ibus_stb    (ibus_stb),
    .ibus_dat_i  (ibus_dat_i),
    .ibus_ack    (ibus_ack),
    .ibus_err    (ibus_err),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instruction (instruction),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .fetch_err   (fetch_err),
    .misaligned  (misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] target;
    logic        exp_mis;
    logic [31:0] exp_next;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [31:0] exp_pc, tgt, sv_instr, sv_pc;
    logic        sv_valid, hold_pending, st, rd;
    int          lat, since_acc, accepted;

    tbl[0] = '{32'h0000_0102, 1'b1, 32'h0};
    tbl[1] = '{32'h0000_0200, 1'b0, 32'h0000_0204};
    tbl[2] = '{32'h0000_0003, 1'b1, 32'h0};
    tbl[3] = '{32'hFFFF_FFFC, 1'b0, 32'h0000_0000};
    tbl[4] = '{32'h0000_1001, 1'b1, 32'h0};
    tbl[5] = '{32'h0000_0010, 1'b0, 32'h0000_0014};

    rst_n = 1'b0; ibus_ack = 1'b0; ibus_err = 1'b0; ibus_dat_i = 32'h0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    @(negedge clk); @(negedge clk);
    chk1("rst_cyc", ibus_cyc, 1'b0);
    chk1("rst_valid", inst_valid, 1'b0);
    chk("rst_instr", instruction, NOP);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk1("rst_flags", fetch_err | misaligned, 1'b0);

    // Reset release, ack every cycle.
    rst_n = 1'b1;
    @(negedge clk);
    chk1("first_req_valid", inst_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk1("seq_cyc", ibus_cyc, 1'b1);
      chk("seq_addr", ibus_addr, 32'(i * 4));
      ibus_ack = 1'b1; ibus_dat_i = mem(32'(i * 4));
      @(negedge clk);
      chk1("seq_valid", inst_valid, 1'b1);
      chk("seq_pc", inst_pc, 32'(i * 4));
      chk("seq_instr", instruction, mem(32'(i * 4)));
    end
    ibus_ack = 1'b0;

    // Stall during outstanding request to 0x10, acked with 0x00500093.
    stall = 1'b1;
    @(negedge clk);
    chk("stall_hold_pc", inst_pc, 32'hC);
    chk1("stall_hold_valid", inst_valid, 1'b1);
    chk("stall_addr", ibus_addr, 32'h10);
    ibus_ack = 1'b1; ibus_dat_i = 32'h0050_0093;
    @(negedge clk);
    ibus_ack = 1'b0;
    chk1("buf_no_req", ibus_cyc, 1'b0);
    chk("buf_hold_pc", inst_pc, 32'hC);
    chk("buf_hold_instr", instruction, mem(32'hC));
    @(negedge clk);
    chk1("buf_no_req2", ibus_cyc, 1'b0);
    stall = 1'b0;
    @(negedge clk);
    chk("drain_instr", instruction, 32'h0050_0093);
    chk("drain_pc", inst_pc, 32'h10);
    chk1("drain_valid", inst_valid, 1'b1);
    chk("drain_next_addr", ibus_addr, 32'h14);

    // Redirect + stall + ack in one cycle: redirect wins.
    redirect = 1'b1; redirect_pc = 32'h8; stall = 1'b1;
    ibus_ack = 1'b1; ibus_dat_i = 32'hBAD0_0001;
    @(negedge clk);
    redirect = 1'b0; stall = 1'b0; ibus_ack = 1'b0;
    chk1("rsa_valid", inst_valid, 1'b0);
    chk("rsa_instr", instruction, NOP);
    chk("rsa_addr", ibus_addr, 32'h8);
    @(negedge clk);
    chk1("rsa_buf_empty", inst_valid, 1'b0);

    // Redirect to 0x100 while 0x8 outstanding; ack arrives 3 cycles later.
    redirect = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("kill_addr", ibus_addr, 32'h8);
      chk1("kill_cyc", ibus_cyc, 1'b1);
      chk1("kill_valid", inst_valid, 1'b0);
      @(negedge clk);
    end
    ibus_ack = 1'b1; ibus_dat_i = 32'hDEAD_BEEF;
    @(negedge clk);
    ibus_ack = 1'b0;
    chk1("kill_discard", inst_valid, 1'b0);
    chk("kill_resume_addr", ibus_addr, 32'h100);
    ibus_ack = 1'b1; ibus_dat_i = mem(32'h100);
    @(negedge clk);
    chk("resume_pc", inst_pc, 32'h100);
    chk("resume_instr", instruction, mem(32'h100));

    // Bus error on fetch of 0x40.
    redirect = 1'b1; redirect_pc = 32'h40; ibus_dat_i = 32'hBAD0_0002;
    @(negedge clk);
    redirect = 1'b0; ibus_ack = 1'b0;
    chk("err_addr", ibus_addr, 32'h40);
    ibus_err = 1'b1;
    @(negedge clk);
    ibus_err = 1'b0;
    chk1("err_flag", fetch_err, 1'b1);
    chk1("err_valid", inst_valid, 1'b1);
    chk("err_pc", inst_pc, 32'h40);
    chk("err_instr", instruction, NOP);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("halt_no_req", ibus_cyc, 1'b0);
      chk1("halt_err_held", fetch_err, 1'b1);
    end
    redirect = 1'b1; redirect_pc = 32'h80;
    @(negedge clk);
    redirect = 1'b0;
    chk1("halt_exit_err", fetch_err, 1'b0);
    chk("halt_exit_addr", ibus_addr, 32'h80);
    chk1("halt_exit_cyc", ibus_cyc, 1'b1);

    // Redirect target table.
    for (int i = 0; i < 6; i++) begin
      redirect = 1'b1; redirect_pc = tbl[i].target;
      ibus_ack = ibus_cyc; ibus_dat_i = 32'hBAD0_0003;
      @(negedge clk);
      redirect = 1'b0; ibus_ack = 1'b0;
      if (tbl[i].exp_mis) begin
        chk1("tbl_mis_cyc", ibus_cyc, 1'b0);
        chk1("tbl_mis_flag", misaligned, 1'b1);
        chk1("tbl_mis_valid", inst_valid, 1'b1);
        chk("tbl_mis_pc", inst_pc, tbl[i].target);
        chk("tbl_mis_instr", instruction, NOP);
        @(negedge clk);
        chk1("tbl_halt_cyc", ibus_cyc, 1'b0);
        chk1("tbl_halt_mis", misaligned, 1'b1);
      end else begin
        chk1("tbl_cyc", ibus_cyc, 1'b1);
        chk("tbl_addr", ibus_addr, tbl[i].target);
        chk1("tbl_valid0", inst_valid, 1'b0);
        ibus_ack = 1'b1; ibus_dat_i = mem(tbl[i].target);
        @(negedge clk);
        ibus_ack = 1'b0;
        chk("tbl_pc", inst_pc, tbl[i].target);
        chk("tbl_instr", instruction, mem(tbl[i].target));
        chk("tbl_next", ibus_addr, tbl[i].exp_next);
      end
    end

    // Reset mid-transaction; an ack after release must be ignored.
    rst_n = 1'b0;
    #1;
    chk1("rst_mid_cyc", ibus_cyc, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; ibus_ack = 1'b1; ibus_dat_i = 32'hBAD0_0004;
    @(negedge clk);
    ibus_ack = 1'b0;
    chk1("rst_late_ack", inst_valid, 1'b0);
    chk("rst_restart_addr", ibus_addr, 32'h0);

    // Randomized run against a program-order stream model.
    exp_pc = 32'h0; lat = 0; since_acc = 0; accepted = 0; hold_pending = 1'b0;
    sv_instr = 32'h0; sv_pc = 32'h0; sv_valid = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      chk1("rnd_stb", ibus_stb, ibus_cyc);
      chk1("rnd_flags", fetch_err | misaligned, 1'b0);
      if (hold_pending) begin
        chk("rnd_hold_instr", instruction, sv_instr);
        chk("rnd_hold_pc", inst_pc, sv_pc);
        chk1("rnd_hold_valid", inst_valid, sv_valid);
      end
      st  = ($urandom_range(0, 9) < 3);
      rd  = ($urandom_range(0, 29) == 0);
      tgt = $urandom_range(0, 1023) << 2;
      if (inst_valid && !st) begin
        chk("rnd_pc", inst_pc, exp_pc);
        chk("rnd_instr", instruction, mem(exp_pc));
        exp_pc = exp_pc + 32'd4;
        accepted++;
        since_acc = 0;
      end else begin
        since_acc++;
      end
      if (rd) exp_pc = tgt;
      hold_pending = st && !rd;
      sv_instr = instruction; sv_pc = inst_pc; sv_valid = inst_valid;
      if (ibus_cyc) begin
        if (lat == 0) begin
          ibus_ack = 1'b1; ibus_dat_i = mem(ibus_addr);
          lat = $urandom_range(0, 2);
        end else begin
          ibus_ack = 1'b0; lat--;
        end
      end else begin
        ibus_ack = 1'b0;
      end
      stall = st; redirect = rd; redirect_pc = tgt;
      if (since_acc > 200) begin
        n_vec++; n_err++;
        $display("FAIL rnd_progress: no instruction accepted for %0d cycles, required <= 200",
                 since_acc);
        break;
      end
    end
    stall = 1'b0; redirect = 1'b0; ibus_ack = 1'b0;
    n_vec++;
    if (accepted < 500) begin
      n_err++;
      $display("FAIL rnd_throughput: accepted %0d instructions, required >= 500", accepted);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_ADDR, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port rst_n  in  1  async active-low reset.
REQ-005 SHALL have port ibus_addr  out  32  word-aligned fetch address.
REQ-006 SHALL have port ibus_cyc  out  1  bus cycle active.
REQ-007 SHALL have port ibus_stb  out  1  request strobe, equal to ibus_cyc.
REQ-008 SHALL have port ibus_dat_i  in  32  returned instruction word.
REQ-009 SHALL have port ibus_ack  in  1  request completed, data valid.
REQ-010 SHALL have port ibus_err  in  1  request failed, access fault.
REQ-011 SHALL have port stall  in  1  decode stage cannot accept.
REQ-012 SHALL have port redirect  in  1  branch, jump, trap or mret taken.
REQ-013 SHALL have port redirect_pc  in  32  new fetch target.
REQ-014 SHALL have port instruction  out  32  word driven to the decoder.
REQ-015 SHALL have port inst_pc  out  32  address of instruction.
REQ-016 SHALL have port inst_valid  out  1  instruction/inst_pc meaningful.
REQ-017 SHALL have port fetch_err  out  1  access fault on inst_pc, valid with inst_valid.
REQ-018 SHALL have port misaligned  out  1  redirect target not word aligned, valid with inst_valid.

Function
REQ-019 SHALL implement FSM states IDLE, REQ, KILL and HALT.
REQ-020 IDLE SHALL move to REQ when not stalled, or when stalled with the buffer empty.
REQ-021 REQ SHALL drive ibus_cyc=ibus_stb=1 and ibus_addr=pc until ack or err.
REQ-022 On ack in REQ with stall=0: instruction<=ibus_dat_i, inst_pc<=pc, inst_valid<=1, pc<=pc+4 (modulo 2^32), stay in REQ.
REQ-023 Throughput SHALL be one instruction per ack; the next address is presented the cycle after ack.
REQ-024 On ack in REQ with stall=1: the word/pc SHALL go to the 1-entry buffer, the FSM SHALL go to IDLE, and no new request SHALL issue while the buffer is full.
REQ-025 While stall=1, instruction, inst_pc, inst_valid, fetch_err and misaligned SHALL hold.
REQ-026 When stall falls with the buffer full, the buffer SHALL drive the outputs on the next edge and empty.
REQ-027 redirect SHALL have priority over stall, ack and buffer.
- effect: pc<=redirect_pc, buffer cleared, inst_valid<=0, instruction<=NOP (32'h0000_0013).
REQ-028 If redirect arrives in REQ without ack/err the same cycle, the FSM SHALL enter KILL.
- KILL keeps cyc/stb until ack or err, discards the response, then enters REQ at redirect_pc.
REQ-029 If redirect arrives in REQ with ack the same cycle, the acked word SHALL be discarded.
REQ-030 If redirect_pc[1:0]!=0: no bus request; next edge inst_valid=1, misaligned=1, inst_pc=redirect_pc, instruction=NOP; FSM enters HALT.
REQ-031 On err in REQ: inst_valid=1, fetch_err=1, inst_pc=pc, instruction=NOP; pc not advanced; FSM enters HALT.
REQ-032 HALT SHALL issue no requests and leave only on redirect.
REQ-033 fetch_err and misaligned SHALL be 0 whenever inst_valid=0, and SHALL clear on the next accepted instruction or redirect.

Reset
REQ-034 Reset SHALL set pc=RESET_ADDR, instruction=NOP, inst_pc=RESET_ADDR and inst_valid=fetch_err=misaligned=0.
- also: ibus_cyc=ibus_stb=0, buffer empty, FSM=IDLE.
REQ-035 The first request SHALL assert the first rising edge after rst_n deasserts.
REQ-036 Reset mid-transaction SHALL drop cyc/stb immediately; a later ack SHALL be ignored.

Structure
REQ-037 The NOP encoding, FSM state encodings and RESET_ADDR default SHALL live in the shared def header.
REQ-038 The 1-entry holding buffer (word, pc, full flag) SHALL be the sub-module fetch_buffer.

Verification
REQ-039 Reset release, ack every cycle -> addresses 0,4,8,12 in consecutive requests; inst_valid from the cycle after the first ack.
REQ-040 Stall asserted during an outstanding request, ack of 0x00500093 -> outputs hold; word presented the cycle after stall drops; no request while buffered.
REQ-041 Redirect to 0x100 while a request to 0x8 is outstanding, ack 3 cycles later -> data discarded, next request addr 0x100, inst_valid=0 meanwhile.
REQ-042 redirect_pc=0x102 -> no bus cycle; inst_valid=1, misaligned=1, inst_pc=0x102, instruction=0x00000013; HALT until the next redirect.
REQ-043 ibus_err on fetch of 0x40 -> fetch_err=1, inst_pc=0x40, no further requests until redirect to 0x80 resumes at 0x80.
REQ-044 Redirect and stall in the same cycle as an ack -> redirect wins; buffer empty; next request at redirect_pc.
